eeg_pea_eng_feed: RTL and testbench

Operand feeder directly upstream of the PE engine. It loads one kernel of weights, walks a strided activation address range in ARAM (1-cycle read latency), and emits the PE's DIN stream: for each activation address, one beat per kernel tap, flagged with WEI_LST on the last tap and ACT_LST on the final address. A 2-entry activation prefetch FIFO sustains one beat per cycle under DIN_RDY backpressure.

---
 rtl/eeg_pea_eng_feed_if.sv | 34 +++
 rtl/eeg_pea_eng_feed.sv | 153 +++++++++++++++
 tb/tb_eeg_pea_eng_feed.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eeg_pea_eng_feed_if.sv
// Operand-feeder bus bundle: weight load, ARAM read port and PE DIN stream.
// master = feeder side, slave = environment (weight source, ARAM, PE).
interface eeg_pea_eng_feed_if #(
    parameter int ACT_DW      = 8,
    parameter int WEI_DW      = 8,
    parameter int ARAM_ADD_AW = 10,
    parameter int CONV_WEI_DW = 3
);
    logic                   WEI_IN_VLD;
    logic                   WEI_IN_RDY;
    logic [WEI_DW-1:0]      WEI_IN_DAT;
    logic                   ARAM_RD_ENA;
    logic [ARAM_ADD_AW-1:0] ARAM_RD_ADD;
    logic [ACT_DW-1:0]      ARAM_RD_DAT;
    logic                   DIN_VLD;
    logic                   DIN_RDY;
    logic                   ACT_LST;
    logic                   WEI_LST;
    logic [ACT_DW-1:0]      ACT_DAT;
    logic [ARAM_ADD_AW-1:0] ACT_ADD;
    logic [WEI_DW-1:0]      WEI_DAT;
    logic [CONV_WEI_DW-1:0] WEI_IDX;

    modport master (
        input  WEI_IN_VLD, WEI_IN_DAT, ARAM_RD_DAT, DIN_RDY,
        output WEI_IN_RDY, ARAM_RD_ENA, ARAM_RD_ADD, DIN_VLD, ACT_LST, WEI_LST,
               ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX
    );
    modport slave (
        output WEI_IN_VLD, WEI_IN_DAT, ARAM_RD_DAT, DIN_RDY,
        input  WEI_IN_RDY, ARAM_RD_ENA, ARAM_RD_ADD, DIN_VLD, ACT_LST, WEI_LST,
               ACT_DAT, ACT_ADD, WEI_DAT, WEI_IDX
    );
endinterface

// File: rtl/eeg_pea_eng_feed.sv
// PE operand feeder: loads a weight kernel, walks strided ARAM addresses, emits one beat per tap.
// Optional FEED_PERF_CNT_EN adds saturating busy/stall performance counters.
module eeg_pea_eng_feed #(
    parameter int ACT_DW      = 8,
    parameter int WEI_DW      = 8,
    parameter int ARAM_ADD_AW = 10,
    parameter int CONV_WEI_DW = 3,
    parameter int CONV_RUN_DW = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   IS_IDLE,
    input  logic                   CFG_START,
    input  logic [ARAM_ADD_AW-1:0] CFG_ACT_STA,
    input  logic [ARAM_ADD_AW-1:0] CFG_ACT_END,
    input  logic [CONV_RUN_DW-1:0] CFG_ACT_STP,
    input  logic [CONV_WEI_DW-1:0] CFG_CONV_WEI,
    output logic                   DONE,
`ifdef FEED_PERF_CNT_EN
    output logic [31:0]            PERF_BUSY_CNT,
    output logic [31:0]            PERF_STALL_CNT,
`endif
    eeg_pea_eng_feed_if.master     bus
);
    localparam int WEI_NW = 2 ** CONV_WEI_DW;
    localparam int PW     = ARAM_ADD_AW + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]             state;
    logic [PW-1:0]          ptr;
    logic [ARAM_ADD_AW-1:0] end_r;
    logic [ARAM_ADD_AW-1:0] rd_add_q;
    logic [CONV_RUN_DW-1:0] stp_r;
    logic [CONV_WEI_DW-1:0] tap_m1;
    logic [CONV_WEI_DW-1:0] wcnt;
    logic [CONV_WEI_DW-1:0] k;
    logic [WEI_DW-1:0]      w [WEI_NW];
    logic [ACT_DW-1:0]      f_dat [2];
    logic [ARAM_ADD_AW-1:0] f_add [2];
    logic                   f_wp, f_rp;
    logic [1:0]             f_cnt;
    logic                   inflight;
    logic                   done_r;

    logic din_vld, tap_lst, head_lst, hs, pop, fin, rd_ena;

    always_comb begin
        din_vld  = (state == S_STREAM) && (f_cnt != 2'd0);
        tap_lst  = (k == tap_m1);
        // Carry into bit ARAM_ADD_AW means the next address is past END.
        head_lst = ({1'b0, f_add[f_rp]} + PW'(stp_r)) > {1'b0, end_r};
        hs       = din_vld && bus.DIN_RDY;
        pop      = hs && tap_lst;
        fin      = pop && head_lst;
        // Reserve a FIFO slot for every read still in the 1-cycle ARAM pipe.
        rd_ena   = (state == S_STREAM) && (ptr <= {1'b0, end_r}) &&
                   ((3'(f_cnt) + 3'(inflight) - 3'(pop)) < 3'd2);
    end

    assign IS_IDLE         = (state == S_IDLE);
    assign DONE            = done_r;
    assign bus.WEI_IN_RDY  = (state == S_LOAD);
    assign bus.ARAM_RD_ENA = rd_ena;
    assign bus.ARAM_RD_ADD = ptr[ARAM_ADD_AW-1:0];
    assign bus.DIN_VLD     = din_vld;
    assign bus.ACT_DAT     = f_dat[f_rp];
    assign bus.ACT_ADD     = f_add[f_rp];
    assign bus.WEI_DAT     = w[k];
    assign bus.WEI_IDX     = k;
    assign bus.WEI_LST     = din_vld && tap_lst;
    assign bus.ACT_LST     = din_vld && head_lst;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ptr      <= '0;
            end_r    <= '0;
            rd_add_q <= '0;
            stp_r    <= '0;
            tap_m1   <= '0;
            wcnt     <= '0;
            k        <= '0;
            f_wp     <= 1'b0;
            f_rp     <= 1'b0;
            f_cnt    <= '0;
            inflight <= 1'b0;
            done_r   <= 1'b0;
            for (int i = 0; i < WEI_NW; i++) w[i] <= '0;
            for (int i = 0; i < 2; i++) begin
                f_dat[i] <= '0;
                f_add[i] <= '0;
            end
        end else begin
            done_r   <= 1'b0;
            inflight <= rd_ena;
            if (rd_ena) begin
                ptr      <= ptr + PW'(stp_r);
                rd_add_q <= ptr[ARAM_ADD_AW-1:0];
            end
            if (inflight) begin
                f_dat[f_wp] <= bus.ARAM_RD_DAT;
                f_add[f_wp] <= rd_add_q;
                f_wp        <= ~f_wp;
            end
            if (pop) f_rp <= ~f_rp;
            f_cnt <= f_cnt + 2'(inflight) - 2'(pop);
            if (hs) k <= tap_lst ? '0 : k + 1'b1;

            case (state)
                S_IDLE: if (CFG_START) begin
                    end_r    <= CFG_ACT_END;
                    stp_r    <= (CFG_ACT_STP == '0) ? CONV_RUN_DW'(1) : CFG_ACT_STP;
                    tap_m1   <= CFG_CONV_WEI;
                    ptr      <= {1'b0, CFG_ACT_STA};
                    wcnt     <= '0;
                    k        <= '0;
                    f_wp     <= 1'b0;
                    f_rp     <= 1'b0;
                    f_cnt    <= '0;
                    if (CFG_ACT_STA > CFG_ACT_END) done_r <= 1'b1;
                    else                           state  <= S_LOAD;
                end
                S_LOAD: if (bus.WEI_IN_VLD) begin
                    w[wcnt] <= bus.WEI_IN_DAT;
                    wcnt    <= wcnt + 1'b1;
                    if (wcnt == tap_m1) state <= S_STREAM;
                end
                S_STREAM: if (fin) begin
                    state  <= S_IDLE;
                    done_r <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FEED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || (IS_IDLE && CFG_START)) begin
            PERF_BUSY_CNT  <= '0;
            PERF_STALL_CNT <= '0;
        end else begin
            if (!IS_IDLE && (PERF_BUSY_CNT != '1))
                PERF_BUSY_CNT <= PERF_BUSY_CNT + 32'd1;
            if (din_vld && !bus.DIN_RDY && (PERF_STALL_CNT != '1))
                PERF_STALL_CNT <= PERF_STALL_CNT + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_eeg_pea_eng_feed.sv
// Self-checking bench for eeg_pea_eng_feed: vector table, random configs, reset and perf corners.
module tb_eeg_pea_eng_feed;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       is_idle, done, cfg_start;
    logic [9:0] cfg_sta, cfg_end;
    logic [2:0] cfg_stp, cfg_cw;
`ifdef FEED_PERF_CNT_EN
    logic [31:0] perf_busy, perf_stall;
`endif

    eeg_pea_eng_feed_if #(.ACT_DW(8), .WEI_DW(8), .ARAM_ADD_AW(10), .CONV_WEI_DW(3)) bus ();

    eeg_pea_eng_feed #(.ACT_DW(8), .WEI_DW(8), .ARAM_ADD_AW(10), .CONV_WEI_DW(3), .CONV_RUN_DW(3)) dut (
        .clk(clk), .rst_n(rst_n), .IS_IDLE(is_idle), .CFG_START(cfg_start),
        .CFG_ACT_STA(cfg_sta), .CFG_ACT_END(cfg_end), .CFG_ACT_STP(cfg_stp),
        .CFG_CONV_WEI(cfg_cw), .DONE(done),
`ifdef FEED_PERF_CNT_EN
        .PERF_BUSY_CNT(perf_busy), .PERF_STALL_CNT(perf_stall),
`endif
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] act;
        logic [9:0] add;
        logic [7:0] wei;
        logic [2:0] idx;
        logic       wl;
        logic       al;
    } beat_t;

    typedef struct {
        int sta; int en; int stp; int cw; int nbeats; int nreads; bit rr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [1024];
    logic [7:0] wts [8];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ARAM model: 1-cycle read latency
    always @(posedge clk) if (bus.ARAM_RD_ENA) bus.ARAM_RD_DAT <= mem[bus.ARAM_RD_ADD];

    bit rdy_rand = 1'b0;
    bit rdy_fix  = 1'b1;
    bit rnd_bit  = 1'b0;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign bus.DIN_RDY = rdy_rand ? rnd_bit : rdy_fix;

    // Append-only observation record; the main process only reads it.
    beat_t got[$];
    int    got_cyc[$], rd_cyc[$], vld_cyc[$];
    int    rd_cnt = 0, bad_rd = 0, wrdy_cnt = 0, stab_bad = 0, done_cnt = 0, done_cyc = -1;
    beat_t prev_b;
    bit    prev_stall = 1'b0;

    always @(negedge clk) begin
        beat_t cur;
        cur = '{bus.ACT_DAT, bus.ACT_ADD, bus.WEI_DAT, bus.WEI_IDX, bus.WEI_LST, bus.ACT_LST};
        if (!rst_n) prev_stall = 1'b0;
        else begin
            if (prev_stall && (!bus.DIN_VLD || cur != prev_b)) stab_bad++;
            prev_stall = bus.DIN_VLD && !bus.DIN_RDY;
            prev_b     = cur;
            if (bus.DIN_VLD) begin
                vld_cyc.push_back(cyc);
                if (bus.DIN_RDY) begin
                    got.push_back(cur);
                    got_cyc.push_back(cyc);
                end
            end
            if (bus.ARAM_RD_ENA) begin
                rd_cnt++;
                rd_cyc.push_back(cyc);
                if (is_idle || bus.WEI_IN_RDY) bad_rd++;
            end
            if (bus.WEI_IN_RDY) wrdy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int sta, input int en, input int stp, input int cw);
        cfg_sta = 10'(sta); cfg_end = 10'(en); cfg_stp = 3'(stp); cfg_cw = 3'(cw);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic load_w(input int cw, input bit gaps);
        for (int i = 0; i <= cw; i++) begin
            int g;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.WEI_IN_VLD = 1'b0;
                step();
            end
            bus.WEI_IN_VLD = 1'b1;
            bus.WEI_IN_DAT = wts[i];
            g = 0;
            while (!bus.WEI_IN_RDY && g < 20) begin step(); g++; end
            if (g >= 20) chk("wei_rdy_timeout", 0, 1);
            step();
        end
        bus.WEI_IN_VLD = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int g = 0;
        while (done_cnt == d0 && g < 3000) begin step(); g++; end
        if (g >= 3000) chk("done_timeout", 0, 1);
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_idle"}, longint'(is_idle), 1);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_outs"}, longint'({bus.DIN_VLD, bus.ARAM_RD_ENA, bus.WEI_IN_RDY, bus.ACT_LST,
            bus.WEI_LST, bus.ACT_DAT, bus.ACT_ADD, bus.WEI_DAT, bus.WEI_IDX, bus.ARAM_RD_ADD}), 0);
    endtask

    // Reference: enumerate addresses STA, STA+S, ... <= END, each expanded into T taps.
    task automatic run(input int sta, input int en, input int stp, input int cw, input bit rr,
                       input int nb_exp, input int nr_exp, input bit inject);
        beat_t exp[$];
        int b0, r0, d0, rv0, vv0, wr0, sb0, br0, sc, s, last;
        b0 = got.size(); r0 = rd_cnt; d0 = done_cnt; rv0 = rd_cyc.size();
        vv0 = vld_cyc.size(); wr0 = wrdy_cnt; sb0 = stab_bad; br0 = bad_rd;
        for (int i = 0; i < 8; i++) wts[i] = 8'($urandom);
        s = (stp == 0) ? 1 : stp;
        for (int a = sta; a <= en; a += s)
            for (int t = 0; t <= cw; t++)
                exp.push_back('{mem[a], 10'(a), wts[t], 3'(t), t == cw, (a + s) > en});
        rdy_rand = rr;
        rdy_fix  = 1'b1;
        start(sta, en, stp, cw);
        sc = cyc;
        if (sta <= en) load_w(cw, 1'b1);
        if (inject) begin
            repeat (3) step();
            start(0, 1023, 1, 7);
        end
        wait_done(d0);
        repeat (3) step();
        rdy_rand = 1'b0;
        chk("done_pulses", done_cnt - d0, 1);
        chk("idle_after", longint'(is_idle), 1);
        chk("nbeats", got.size() - b0, nb_exp);
        for (int i = 0; i < exp.size(); i++)
            if (b0 + i < got.size()) chk($sformatf("beat%0d", i), longint'(got[b0 + i]), longint'(exp[i]));
        chk("nreads", rd_cnt - r0, nr_exp);
        chk("stable_stall", stab_bad - sb0, 0);
        chk("rd_outside_stream", bad_rd - br0, 0);
        if (sta > en) begin
            chk("empty_done_cyc", done_cyc, sc);
            chk("empty_wrdy", wrdy_cnt - wr0, 0);
        end else if (got.size() > b0 && rd_cyc.size() > rv0 && vld_cyc.size() > vv0) begin
            last = got.size() - 1;
            chk("first_vld_lat", vld_cyc[vv0] - rd_cyc[rv0], 2);
            chk("done_lat", done_cyc, got_cyc[last] + 1);
            if (!rr) chk("back2back", got_cyc[last] - got_cyc[b0], nb_exp - 1);
        end
    endtask

    initial begin
        vec_t tbl[7];
        tbl[0] = '{0,    3,    1, 2, 12,  4,  1'b0};
        tbl[1] = '{5,    12,   3, 0, 3,   3,  1'b0};
        tbl[2] = '{1020, 1023, 7, 1, 2,   1,  1'b0};
        tbl[3] = '{9,    4,    1, 2, 0,   0,  1'b0};
        tbl[4] = '{10,   20,   0, 3, 44,  11, 1'b0};
        tbl[5] = '{0,    100,  7, 7, 120, 15, 1'b0};
        tbl[6] = '{0,    3,    1, 2, 12,  4,  1'b1};

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        cfg_start = 1'b0; cfg_sta = '0; cfg_end = '0; cfg_stp = '0; cfg_cw = '0;
        bus.WEI_IN_VLD = 1'b0; bus.WEI_IN_DAT = '0;
        repeat (3) step();
        check_rst("reset");
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) run(tbl[i].sta, tbl[i].en, tbl[i].stp, tbl[i].cw, tbl[i].rr,
                             tbl[i].nbeats, tbl[i].nreads, 1'b0);

        // CFG_START while streaming must not disturb the run.
        run(0, 3, 1, 2, 1'b0, 12, 4, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int sta, en, stp, cw, s, n;
            sta = $urandom_range(0, 1023);
            en  = ($urandom_range(0, 7) == 0) ? sta - 1 : sta + $urandom_range(0, 40);
            if (en > 1023) en = 1023;
            stp = $urandom_range(0, 7);
            cw  = $urandom_range(0, 7);
            s = (stp == 0) ? 1 : stp;
            n = 0;
            for (int a = sta; a <= en; a += s) n++;
            run(sta, en, stp, cw, 1'b1, n * (cw + 1), n, 1'b0);
        end

        // Reset in the middle of a stream aborts with no DONE.
        begin
            int b0, d0, g;
            b0 = got.size();
            for (int i = 0; i < 8; i++) wts[i] = 8'($urandom);
            start(0, 50, 1, 3);
            load_w(3, 1'b0);
            g = 0;
            while (got.size() - b0 < 5 && g < 100) begin step(); g++; end
            chk("pre_rst_stream", longint'(got.size() - b0 >= 5), 1);
            rst_n = 1'b0;
            step();
            check_rst("midrst");
            rst_n = 1'b1;
            d0 = done_cnt;
            repeat (10) step();
            chk("no_done_after_rst", done_cnt - d0, 0);
            chk("idle_after_rst", longint'(is_idle), 1);
        end

`ifdef FEED_PERF_CNT_EN
        begin
            int b0, d0, sc, g;
            b0 = got.size(); d0 = done_cnt;
            for (int i = 0; i < 8; i++) wts[i] = 8'($urandom);
            start(0, 3, 1, 2);
            sc = cyc;
            load_w(2, 1'b0);
            g = 0;
            while (got.size() - b0 < 2 && g < 100) begin step(); g++; end
            rdy_fix = 1'b0;
            repeat (3) step();
            rdy_fix = 1'b1;
            wait_done(d0);
            step();
            chk("perf_stall", perf_stall, 3);
            chk("perf_busy", perf_busy, done_cyc - sc);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
